ihex_loader: RTL and testbench
==============================

IHEX_LOADER -- requirements
Module: ihex_loader

Interface
REQ-001 Parameter ADDR_W, default 32, width of o_mem_addr; values above 32 zero-extend, values below 32 truncate the upper bits.
REQ-002 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 i_rdy  input  1  one-cycle strobe; i_data holds a received ASCII byte.
REQ-005 i_data  input  8  received ASCII character.
REQ-006 o_mem_valid  output  1  write request pending.
REQ-007 i_mem_ready  input  1  memory accepts the write when o_mem_valid is also high.
REQ-008 o_mem_addr  output  ADDR_W  byte write address.
REQ-009 o_mem_data  output  8  byte write data.
REQ-010 o_busy  output  1  high while a record is being parsed (any state except IDLE).
REQ-011 o_done  output  1  sticky; EOF record accepted.
REQ-012 o_err  output  1  one-cycle error pulse.
REQ-013 o_err_code  output  2  0 bad char, 1 checksum, 2 overrun, 3 unexpected ':'; holds until the next error.

Function
REQ-014 The parser SHALL have states IDLE, COUNT, ADDR_HI, ADDR_LO, TYPE, DATA, CSUM, with a nibble-phase flag; each field byte consumes two hex characters, high nibble first.
REQ-015 In IDLE, ':' SHALL move to COUNT, clear o_done and reset the running checksum; every other character is ignored.
REQ-016 Hex characters 0-9, A-F and a-f SHALL be accepted; any other character outside IDLE SHALL pulse o_err with code 0 and return to IDLE.
REQ-017 A ':' outside IDLE SHALL pulse o_err with code 3 and restart at COUNT.
REQ-018 After TYPE, the parser SHALL go to DATA if the count is nonzero, otherwise to CSUM; DATA goes to CSUM after the count-th byte.
REQ-019 Type 00: each data byte SHALL raise o_mem_valid one cycle after the i_rdy of its low nibble, with address {ela, (rec_addr + index) mod 2^16}.
REQ-020 Address and data SHALL stay stable while o_mem_valid is high; o_mem_valid drops the cycle after valid and ready are both high.
REQ-021 If a new data byte completes while o_mem_valid is still high, the block SHALL drop the new byte, pulse o_err with code 2 and keep the pending write.
REQ-022 Type 04: the two data bytes SHALL load ela[15:0] after CSUM passes; no memory writes occur.
REQ-023 Type 01: o_done SHALL be set after CSUM passes.
REQ-024 Types 02, 03 and 05 SHALL be parsed and check-summed, then ignored.
REQ-025 Type-00 writes SHALL commit before checksum validation; a bad checksum does not roll back writes.
REQ-026 After CSUM completes, the block SHALL return to IDLE; a CR or LF there is ignored.

Reset
REQ-027 While i_rst_n is low, the block SHALL hold state IDLE with o_mem_valid=0, o_mem_addr=0, o_mem_data=0, o_busy=0, o_done=0, o_err=0, o_err_code=0, ela=0.
REQ-028 Reset asserted mid-record or with a write pending SHALL drop that write, and the first ':' after release starts a fresh record.

Configuration
REQ-029 With IHEX_CHECKSUM_EN defined, the sum of all record bytes including the checksum SHALL be 0 mod 256; otherwise o_err pulses with code 1, and types 01 and 04 take no effect.
REQ-030 Without IHEX_CHECKSUM_EN, the checksum byte SHALL still be consumed but not compared, and code 1 is never produced.

Structure
REQ-031 Package ihex_pkg SHALL hold the state enum, record-type constants (REC_DATA=0, REC_EOF=1, REC_ELA=4) and error-code constants.
REQ-032 Sub-module ihex_ascii2nib SHALL convert ASCII to a 4-bit nibble plus a valid flag, combinationally.

Verification
REQ-033 Send ":0100000055AA" with ready tied high -> one write: addr 0x00000000, data 0x55; o_err never pulses.
REQ-034 Send ":020000040001F9" then ":02001000ABCD76" -> writes 0x00010010=0xAB and 0x00010011=0xCD.
REQ-035 Send ":00000001FF" -> o_done=1 and o_busy=0; a following ':' clears o_done.
REQ-036 Send ":0100000055AB" -> write 0x55 issued, then o_err with code 1 (macro on), or no error (macro off).
REQ-037 Hold i_mem_ready low and send ":020000001122CB" -> first write held stable, second byte gives o_err with code 2; releasing ready completes only 0x11.
REQ-038 Send ":01G0" -> o_err with code 0 on 'G', state IDLE; assert i_rst_n low mid-record -> all outputs 0 immediately.

Source files
------------

// File: rtl/ihex_pkg.sv
// Shared types and constants for the Intel HEX loader.
package ihex_pkg;

    // Parser position within a record
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COUNT   = 3'd1,
        ADDR_HI = 3'd2,
        ADDR_LO = 3'd3,
        TYPE    = 3'd4,
        DATA    = 3'd5,
        CSUM    = 3'd6
    } state_t;

    // Record types acted upon; all others are parsed and ignored
    localparam logic [7:0] REC_DATA = 8'h00;
    localparam logic [7:0] REC_EOF  = 8'h01;
    localparam logic [7:0] REC_ELA  = 8'h04;

    // Error codes reported on o_err_code
    localparam logic [1:0] ERR_BAD_CHAR = 2'd0;
    localparam logic [1:0] ERR_CSUM     = 2'd1;
    localparam logic [1:0] ERR_OVERRUN  = 2'd2;
    localparam logic [1:0] ERR_COLON    = 2'd3;

    // Record start character
    localparam logic [7:0] CHAR_COLON = 8'h3A;

endpackage

// File: rtl/ihex_ascii2nib.sv
// Combinational ASCII hex digit decoder: 0-9, A-F, a-f -> nibble + valid.
module ihex_ascii2nib (
    input  logic [7:0] ch,
    output logic [3:0] nib,
    output logic       valid
);

    // Decode one character; letters share the low nibble 1..6 in both cases
    always_comb begin
        nib   = 4'h0;
        valid = 1'b0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            nib   = ch[3:0];
            valid = 1'b1;
        end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
            nib   = ch[3:0] + 4'd9;
            valid = 1'b1;
        end
    end

endmodule

// File: rtl/ihex_loader.sv
// Intel HEX record parser driving a byte-wide memory write port.
// Optional build macro IHEX_CHECKSUM_EN: verify the record checksum and
// gate EOF / extended-linear-address effects on it; without it the
// checksum byte is consumed but never compared.
module ihex_loader
    import ihex_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rdy,
    input  logic [7:0]        i_data,
    output logic              o_mem_valid,
    input  logic              i_mem_ready,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [1:0]        o_err_code
);

    state_t      state;
    state_t      state_next;

    logic        phase;      // 1: high nibble held, waiting for the low one
    logic [3:0]  hi_nib;
    logic [7:0]  count;
    logic [15:0] rec_addr;
    logic [7:0]  rec_type;
    logic [7:0]  idx;
    logic [15:0] ela;
    logic [15:0] ela_new;

    logic [3:0]  nib;
    logic        hex_valid;
    logic        is_colon;
    logic [7:0]  byte_val;
    logic        csum_pass;

    logic        start;
    logic        nib_take;
    logic        byte_done;
    logic        wr_accept;
    logic        commit;
    logic        err_pulse;
    logic [1:0]  err_kind;

    logic [15:0] wr_offset;
    logic [31:0] wr_addr_full;

    ihex_ascii2nib u_nib (
        .ch    (i_data),
        .nib   (nib),
        .valid (hex_valid)
    );

    assign is_colon     = (i_data == CHAR_COLON);
    assign byte_val     = {hi_nib, nib};
    assign wr_offset    = rec_addr + {8'h00, idx};
    assign wr_addr_full = {ela, wr_offset};
    assign o_busy       = (state != IDLE);

`ifdef IHEX_CHECKSUM_EN
    logic [7:0] csum;
    logic [7:0] csum_sum;

    assign csum_sum  = csum + byte_val;
    assign csum_pass = (csum_sum == 8'h00);

    // Running sum of every byte in the record, cleared on each ':'
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            csum <= 8'h00;
        end else if (start) begin
            csum <= 8'h00;
        end else if (byte_done) begin
            csum <= csum_sum;
        end
    end
`else
    assign csum_pass = 1'b1;
`endif

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: registers use non-blocking assignments so every flop
            // samples pre-edge values regardless of block ordering.
            state <= state_next;
        end
    end

    // Next-state decode plus per-character strobes for the datapath
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_next = state;
        start      = 1'b0;
        nib_take   = 1'b0;
        byte_done  = 1'b0;
        wr_accept  = 1'b0;
        commit     = 1'b0;
        err_pulse  = 1'b0;
        err_kind   = ERR_BAD_CHAR;
        if (i_rdy) begin
            if (state == IDLE) begin
                if (is_colon) begin
                    state_next = COUNT;
                    start      = 1'b1;
                end
            end else if (is_colon) begin
                state_next = COUNT;
                start      = 1'b1;
                err_pulse  = 1'b1;
                err_kind   = ERR_COLON;
            end else if (!hex_valid) begin
                state_next = IDLE;
                err_pulse  = 1'b1;
                err_kind   = ERR_BAD_CHAR;
            end else begin
                nib_take = 1'b1;
                if (phase) begin
                    byte_done = 1'b1;
                    case (state)
                        COUNT:   state_next = ADDR_HI;
                        ADDR_HI: state_next = ADDR_LO;
                        ADDR_LO: state_next = TYPE;
                        TYPE:    state_next = (count != 8'h00) ? DATA : CSUM;
                        DATA: begin
                            if (idx == count - 8'd1) begin
                                state_next = CSUM;
                            end
                            if (rec_type == REC_DATA) begin
                                // A write retiring this very cycle frees the slot
                                if (o_mem_valid && !i_mem_ready) begin
                                    err_pulse = 1'b1;
                                    err_kind  = ERR_OVERRUN;
                                end else begin
                                    wr_accept = 1'b1;
                                end
                            end
                        end
                        CSUM: begin
                            state_next = IDLE;
                            if (csum_pass) begin
                                commit = 1'b1;
                            end else begin
                                err_pulse = 1'b1;
                                err_kind  = ERR_CSUM;
                            end
                        end
                        default: state_next = IDLE;
                    endcase
                end
            end
        end
    end

    // Record fields: nibble assembly, header capture, data index, ELA
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            phase    <= 1'b0;
            hi_nib   <= 4'h0;
            count    <= 8'h00;
            rec_addr <= 16'h0000;
            rec_type <= 8'h00;
            idx      <= 8'h00;
            ela      <= 16'h0000;
            ela_new  <= 16'h0000;
        end else begin
            if (start) begin
                phase <= 1'b0;
            end else if (nib_take) begin
                phase <= ~phase;
                if (!phase) begin
                    hi_nib <= nib;
                end
            end
            if (byte_done) begin
                case (state)
                    COUNT:   count <= byte_val;
                    ADDR_HI: rec_addr[15:8] <= byte_val;
                    ADDR_LO: rec_addr[7:0] <= byte_val;
                    TYPE: begin
                        rec_type <= byte_val;
                        idx      <= 8'h00;
                    end
                    DATA: begin
                        idx <= idx + 8'd1;
                        if (idx == 8'd0) ela_new[15:8] <= byte_val;
                        if (idx == 8'd1) ela_new[7:0]  <= byte_val;
                    end
                    default: ;
                endcase
            end
            if (commit && rec_type == REC_ELA) begin
                ela <= ela_new;
            end
        end
    end

    // Outputs: write port handshake, sticky done, error pulse and code
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_mem_valid <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_data  <= 8'h00;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            o_err_code  <= ERR_BAD_CHAR;
        end else begin
            if (o_mem_valid && i_mem_ready) begin
                o_mem_valid <= 1'b0;
            end
            if (wr_accept) begin
                o_mem_valid <= 1'b1;
                o_mem_addr  <= ADDR_W'(wr_addr_full);
                o_mem_data  <= byte_val;
            end
            if (start) begin
                o_done <= 1'b0;
            end else if (commit && rec_type == REC_EOF) begin
                o_done <= 1'b1;
            end
            o_err <= err_pulse;
            if (err_pulse) begin
                o_err_code <= err_kind;
            end
        end
    end

endmodule

// File: tb/tb_ihex_loader.sv
// Self-checking bench for ihex_loader: table of whole records followed by
// hand-written sequences for overrun, bad characters, stray ':' and reset.
// Expectations follow IHEX_CHECKSUM_EN when it is defined for the build.
module tb_ihex_loader;

`ifdef IHEX_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        i_rdy = 1'b0;
    logic [7:0]  i_data = 8'h00;
    logic        o_mem_valid;
    logic        i_mem_ready = 1'b0;
    logic [31:0] o_mem_addr;
    logic [7:0]  o_mem_data;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [1:0]  o_err_code;

    ihex_loader #(.ADDR_W(32)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_rdy       (i_rdy),
        .i_data      (i_data),
        .o_mem_valid (o_mem_valid),
        .i_mem_ready (i_mem_ready),
        .o_mem_addr  (o_mem_addr),
        .o_mem_data  (o_mem_data),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_err_code  (o_err_code)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    typedef struct {
        string       rec;
        int          n_wr;
        logic [31:0] a0;
        logic [7:0]  d0;
        logic [31:0] a1;
        logic [7:0]  d1;
        int          n_err;
        logic [1:0]  code;
        logic        done;
    } vec_t;

    // Write and error monitor: a write is logged when valid and ready are
    // both high mid-cycle, i.e. the handshake completes at the next edge.
    wr_t wr_q[$];
    int  err_cnt = 0;
    always @(negedge i_clk) begin
        if (i_rst_n && o_mem_valid && i_mem_ready) wr_q.push_back('{o_mem_addr, o_mem_data});
        if (o_err) err_cnt++;
    end

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string rec, input int n_wr, input logic [31:0] a0,
                           input logic [7:0] d0, input logic [31:0] a1, input logic [7:0] d1,
                           input int n_err, input logic [1:0] code, input logic done);
        vec_t v;
        v.rec = rec; v.n_wr = n_wr; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
        v.n_err = n_err; v.code = code; v.done = done;
        vecs.push_back(v);
    endtask

    task automatic send_char(input logic [7:0] c);
        @(posedge i_clk); #1;
        i_rdy  = 1'b1;
        i_data = c;
        @(posedge i_clk); #1;
        i_rdy  = 1'b0;
        i_data = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int k = 0; k < s.len(); k++) send_char(s[k]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    function automatic wr_t wr_at(input int i);
        wr_t w;
        w = '{32'hDEAD_BEEF, 8'hEE};
        if (i < wr_q.size()) w = wr_q[i];
        return w;
    endfunction

    int  wr_base;
    int  err_base;
    wr_t w;

    initial begin
        // Whole-record table (ready tied high); ELA persists between rows
        add_vec(":0100000055AA\r\n",  1, 32'h0000_0000, 8'h55, 32'h0, 8'h00, 0, 2'd0, 1'b0);
        add_vec(":01000100ab53x",     1, 32'h0000_0001, 8'hAB, 32'h0, 8'h00, 0, 2'd0, 1'b0);
        add_vec(":02FFFF00A1B2AD",    2, 32'h0000_FFFF, 8'hA1, 32'h0000_0000, 8'hB2, 0, 2'd0, 1'b0);
        add_vec(":020000040001F9",    0, 32'h0, 8'h00, 32'h0, 8'h00, 0, 2'd0, 1'b0);
        add_vec(":02001000ABCD76",    2, 32'h0001_0010, 8'hAB, 32'h0001_0011, 8'hCD, 0, 2'd0, 1'b0);
        add_vec(":020000021000EC",    0, 32'h0, 8'h00, 32'h0, 8'h00, 0, 2'd0, 1'b0);
        add_vec(":01002000EEF1",      1, 32'h0001_0020, 8'hEE, 32'h0, 8'h00, 0, 2'd0, 1'b0);
        add_vec(":020000040000FA",    0, 32'h0, 8'h00, 32'h0, 8'h00, 0, 2'd0, 1'b0);
        add_vec(":0100000055AB",      1, 32'h0000_0000, 8'h55, 32'h0, 8'h00,
                CSUM_ON ? 1 : 0, 2'd1, 1'b0);
        add_vec(":00000001FE",        0, 32'h0, 8'h00, 32'h0, 8'h00,
                CSUM_ON ? 1 : 0, 2'd1, !CSUM_ON);
        add_vec(":00000001FF",        0, 32'h0, 8'h00, 32'h0, 8'h00, 0, 2'd0, 1'b1);

        // Reset state
        #3 i_rst_n = 1'b0;
        idle(2);
        check("rst_valid", {31'd0, o_mem_valid}, 32'd0);
        check("rst_addr", o_mem_addr, 32'd0);
        check("rst_busy_done_err", {29'd0, o_busy, o_done, o_err}, 32'd0);
        check("rst_code", {30'd0, o_err_code}, 32'd0);
        i_rst_n = 1'b1;
        idle(2);

        // Table-driven records
        for (int i = 0; i < vecs.size(); i++) begin
            wr_base  = wr_q.size();
            err_base = err_cnt;
            i_mem_ready = 1'b1;
            send_str(vecs[i].rec);
            idle(4);
            check($sformatf("v%0d_nwr", i), wr_q.size() - wr_base, vecs[i].n_wr);
            if (vecs[i].n_wr > 0) begin
                w = wr_at(wr_base);
                check($sformatf("v%0d_wr0", i), {w.a[23:0], w.d}, {vecs[i].a0[23:0], vecs[i].d0});
            end
            if (vecs[i].n_wr > 1) begin
                w = wr_at(wr_base + 1);
                check($sformatf("v%0d_wr1", i), {w.a[23:0], w.d}, {vecs[i].a1[23:0], vecs[i].d1});
            end
            check($sformatf("v%0d_nerr", i), err_cnt - err_base, vecs[i].n_err);
            if (vecs[i].n_err > 0)
                check($sformatf("v%0d_code", i), {30'd0, o_err_code}, {30'd0, vecs[i].code});
            check($sformatf("v%0d_done_busy", i), {30'd0, o_done, o_busy}, {30'd0, vecs[i].done, 1'b0});
        end

        // A new ':' clears the sticky done
        send_str(":");
        check("colon_clears_done", {30'd0, o_done, o_busy}, 32'b01);
        send_str("00000001FF");
        idle(2);
        check("eof_again_done", {30'd0, o_done, o_busy}, 32'b10);

        // Non-hex character mid-record
        err_base = err_cnt;
        send_str(":01G");
        idle(1);
        check("badchar_err", err_cnt - err_base, 1);
        check("badchar_code", {30'd0, o_err_code}, 32'd0);
        check("badchar_idle", {31'd0, o_busy}, 32'd0);
        send_str("0");
        idle(1);
        check("idle_ignores", {31'd0, o_busy} + (err_cnt - err_base), 32'd1);

        // Stray ':' restarts the record
        err_base = err_cnt;
        send_str(":01:");
        idle(1);
        check("colon_err", err_cnt - err_base, 1);
        check("colon_code_busy", {29'd0, o_err_code, o_busy}, {29'd0, 2'd3, 1'b1});
        send_str("00000001FF");
        idle(2);
        check("colon_restart_eof", {30'd0, o_done, o_busy}, 32'b10);

        // Overrun: ready held low, second byte dropped, first write held
        i_mem_ready = 1'b0;
        wr_base  = wr_q.size();
        err_base = err_cnt;
        send_str(":0200000011");
        check("wr_latency_valid", {31'd0, o_mem_valid}, 32'd1);
        check("wr_pending", {o_mem_addr[23:0], o_mem_data}, {24'h0, 8'h11});
        send_str("22");
        idle(1);
        check("overrun_err", err_cnt - err_base, 1);
        check("overrun_code", {30'd0, o_err_code}, 32'd2);
        check("held_stable", {o_mem_addr[23:0], o_mem_data}, {24'h0, 8'h11});
        send_str("CB");
        idle(2);
        check("overrun_rest", {31'd0, o_mem_valid} + (err_cnt - err_base) + (wr_q.size() - wr_base), 32'd2);
        i_mem_ready = 1'b1;
        idle(3);
        check("overrun_nwr", wr_q.size() - wr_base, 1);
        w = wr_at(wr_base);
        check("overrun_wr", {w.a[23:0], w.d}, {24'h0, 8'h11});
        check("overrun_valid_drop", {31'd0, o_mem_valid}, 32'd0);

        // Reset mid-record with a write pending
        send_str(":020000040001F9");
        i_mem_ready = 1'b0;
        send_str(":0100000055");
        check("pre_rst_valid", {31'd0, o_mem_valid}, 32'd1);
        @(posedge i_clk); #2;
        i_rst_n = 1'b0;
        #1;
        check("rst_mid_valid_busy", {30'd0, o_mem_valid, o_busy}, 32'd0);
        check("rst_mid_addr_data", o_mem_addr | {24'd0, o_mem_data}, 32'd0);
        check("rst_mid_flags", {28'd0, o_done, o_err, o_err_code}, 32'd0);
        #20 i_rst_n = 1'b1;
        i_mem_ready = 1'b1;
        wr_base  = wr_q.size();
        err_base = err_cnt;
        send_str("55AA");
        send_str(":0100000055AA");
        idle(4);
        check("post_rst_nwr", wr_q.size() - wr_base, 1);
        w = wr_at(wr_base);
        check("post_rst_wr", w.a ^ {24'd0, w.d}, 32'h0000_0055);
        check("post_rst_noerr", err_cnt - err_base, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
